// File: rtl/y86_seq_ctrl.sv
// Y86-64 sequential-core run control: architectural PC, sticky status code,
// executed/retired counters, free-run or single-step sequencing and an optional watchdog.
module y86_seq_ctrl #(
    parameter int unsigned              ADDR_W      = 64,
    parameter logic [ADDR_W-1:0]        RESET_PC    = '0,
    parameter int unsigned              CNT_W       = 32,
    parameter int unsigned              WDOG_CYCLES = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              step_mode_i,
    input  logic              step_i,
    input  logic              hlt_i,
    input  logic              in_mem_i,
    input  logic              in_inst_i,
    input  logic [ADDR_W-1:0] new_pc_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic [2:0]        status_o,
    output logic              running_o,
    output logic              done_o,
    output logic [CNT_W-1:0]  exec_cnt_o,
    output logic [CNT_W-1:0]  retired_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        STAT_AOK = 3'd1,
        STAT_HLT = 3'd2,
        STAT_ADR = 3'd3,
        STAT_INS = 3'd4,
        STAT_TMO = 3'd5
    } status_t;

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [63:0]      WDOG_LIM = 64'(WDOG_CYCLES);

    state_t     state;
    status_t    status;
    logic       exec_step;
    logic       wdog_hit;
    logic [CNT_W-1:0] exec_inc;
    logic [CNT_W-1:0] ret_inc;

    assign status_o = status;

    always_comb begin
        exec_step = 1'b0;
        exec_inc  = exec_cnt_o;
        ret_inc   = retired_o;
        wdog_hit  = 1'b0;
        exec_step = (state == RUN) && (!step_mode_i || step_i);
        if (exec_cnt_o != CNT_MAX) exec_inc = exec_cnt_o + CNT_W'(1);
        if (retired_o != CNT_MAX)  ret_inc  = retired_o + CNT_W'(1);
        // Timeout is judged on the post-increment count, so it fires on the Nth executing cycle.
        wdog_hit  = (WDOG_CYCLES != 0) && (64'(exec_inc) == WDOG_LIM);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            pc_o       <= RESET_PC;
            status     <= STAT_AOK;
            running_o  <= 1'b0;
            done_o     <= 1'b0;
            exec_cnt_o <= '0;
            retired_o  <= '0;
        end else begin
            done_o <= 1'b0;
            case (state)
                IDLE, STOP: begin
                    if (start_i) begin
                        state      <= RUN;
                        running_o  <= 1'b1;
                        pc_o       <= RESET_PC;
                        status     <= STAT_AOK;
                        exec_cnt_o <= '0;
                        retired_o  <= '0;
                    end
                end
                RUN: begin
                    if (exec_step) begin
                        exec_cnt_o <= exec_inc;
                        if (hlt_i) begin
                            status    <= STAT_HLT;
                            retired_o <= ret_inc;
                            state     <= STOP;
                            running_o <= 1'b0;
                            done_o    <= 1'b1;
                        end else if (in_mem_i) begin
                            status    <= STAT_ADR;
                            state     <= STOP;
                            running_o <= 1'b0;
                            done_o    <= 1'b1;
                        end else if (in_inst_i) begin
                            status    <= STAT_INS;
                            state     <= STOP;
                            running_o <= 1'b0;
                            done_o    <= 1'b1;
                        end else begin
                            pc_o      <= new_pc_i;
                            retired_o <= ret_inc;
                            if (wdog_hit) begin
                                status    <= STAT_TMO;
                                state     <= STOP;
                                running_o <= 1'b0;
                                done_o    <= 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    running_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_y86_seq_ctrl.sv
// Directed bench for y86_seq_ctrl: default instance, a watchdog instance (limit 4)
// and a 3-bit-counter instance, all driven from one shared stimulus.
module tb_y86_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst, start, step_mode, step, hlt, in_mem, in_inst;
    logic [63:0] new_pc;

    logic [63:0] a_pc, b_pc, c_pc;
    logic [2:0]  a_st, b_st, c_st;
    logic        a_run, b_run, c_run, a_done, b_done, c_done;
    logic [31:0] a_exec, a_ret, b_exec, b_ret;
    logic [2:0]  c_exec, c_ret;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    y86_seq_ctrl #(.ADDR_W(64), .RESET_PC(64'd0), .CNT_W(32), .WDOG_CYCLES(0)) u_a (
        .clk(clk), .rst(rst), .start_i(start), .step_mode_i(step_mode), .step_i(step),
        .hlt_i(hlt), .in_mem_i(in_mem), .in_inst_i(in_inst), .new_pc_i(new_pc),
        .pc_o(a_pc), .status_o(a_st), .running_o(a_run), .done_o(a_done),
        .exec_cnt_o(a_exec), .retired_o(a_ret));

    y86_seq_ctrl #(.ADDR_W(64), .RESET_PC(64'd0), .CNT_W(32), .WDOG_CYCLES(4)) u_b (
        .clk(clk), .rst(rst), .start_i(start), .step_mode_i(step_mode), .step_i(step),
        .hlt_i(hlt), .in_mem_i(in_mem), .in_inst_i(in_inst), .new_pc_i(new_pc),
        .pc_o(b_pc), .status_o(b_st), .running_o(b_run), .done_o(b_done),
        .exec_cnt_o(b_exec), .retired_o(b_ret));

    y86_seq_ctrl #(.ADDR_W(64), .RESET_PC(64'd0), .CNT_W(3), .WDOG_CYCLES(0)) u_c (
        .clk(clk), .rst(rst), .start_i(start), .step_mode_i(step_mode), .step_i(step),
        .hlt_i(hlt), .in_mem_i(in_mem), .in_inst_i(in_inst), .new_pc_i(new_pc),
        .pc_o(c_pc), .status_o(c_st), .running_o(c_run), .done_o(c_done),
        .exec_cnt_o(c_exec), .retired_o(c_ret));

    // Inputs change and outputs are sampled on the falling edge.
    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic do_reset_start();
        rst = 1'b1; start = 1'b0; step_mode = 1'b0; step = 1'b0;
        hlt = 1'b0; in_mem = 1'b0; in_inst = 1'b0; new_pc = '0;
        cyc();
        rst = 1'b0; start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; step_mode = 1'b0; step = 1'b0;
        hlt = 1'b0; in_mem = 1'b0; in_inst = 1'b0; new_pc = 64'h55;
        cyc();
        checks++; if (a_pc !== 64'd0) begin errors++; $display("FAIL reset_pc got %0h exp 0", a_pc); end
        checks++; if (a_st !== 3'd1) begin errors++; $display("FAIL reset_status got %0d exp 1", a_st); end
        checks++; if (a_run !== 1'b0 || a_done !== 1'b0) begin errors++; $display("FAIL reset_flags got run=%0b done=%0b exp 0 0", a_run, a_done); end
        checks++; if (a_exec !== 32'd0 || a_ret !== 32'd0) begin errors++; $display("FAIL reset_cnt got %0d/%0d exp 0/0", a_exec, a_ret); end
        rst = 1'b0;
        // Idle ignores fault inputs and new_pc.
        hlt = 1'b1;
        cyc();
        checks++; if (a_pc !== 64'd0 || a_st !== 3'd1 || a_run !== 1'b0) begin errors++; $display("FAIL idle_hold got pc=%0h st=%0d run=%0b exp 0 1 0", a_pc, a_st, a_run); end
        hlt = 1'b0;
    endtask

    task automatic test_free_run();
        do_reset_start();
        checks++; if (a_pc !== 64'd0 || a_st !== 3'd1 || a_run !== 1'b1) begin errors++; $display("FAIL start got pc=%0h st=%0d run=%0b exp 0 1 1", a_pc, a_st, a_run); end
        new_pc = 64'd10; cyc();
        checks++; if (a_pc !== 64'd10) begin errors++; $display("FAIL run_pc1 got %0d exp 10", a_pc); end
        new_pc = 64'd20; cyc();
        checks++; if (a_pc !== 64'd20) begin errors++; $display("FAIL run_pc2 got %0d exp 20", a_pc); end
        new_pc = 64'd30; cyc();
        checks++; if (a_pc !== 64'd30) begin errors++; $display("FAIL run_pc3 got %0d exp 30", a_pc); end
        checks++; if (a_ret !== 32'd3 || a_exec !== 32'd3) begin errors++; $display("FAIL run_cnt got %0d/%0d exp 3/3", a_ret, a_exec); end
        // start_i ignored while running
        start = 1'b1; new_pc = 64'd40; cyc(); start = 1'b0;
        checks++; if (a_pc !== 64'd40 || a_exec !== 32'd4) begin errors++; $display("FAIL run_ignore_start got pc=%0d exec=%0d exp 40 4", a_pc, a_exec); end
    endtask

    task automatic test_halt();
        do_reset_start();
        new_pc = 64'h14; cyc();
        hlt = 1'b1; in_mem = 1'b1; new_pc = 64'h99; cyc();
        checks++; if (a_st !== 3'd2) begin errors++; $display("FAIL halt_status got %0d exp 2", a_st); end
        checks++; if (a_pc !== 64'h14) begin errors++; $display("FAIL halt_pc got %0h exp 14", a_pc); end
        checks++; if (a_ret !== 32'd2 || a_exec !== 32'd2) begin errors++; $display("FAIL halt_cnt got %0d/%0d exp 2/2", a_ret, a_exec); end
        checks++; if (a_done !== 1'b1 || a_run !== 1'b0) begin errors++; $display("FAIL halt_flags got done=%0b run=%0b exp 1 0", a_done, a_run); end
        hlt = 1'b0; in_mem = 1'b0; cyc();
        checks++; if (a_done !== 1'b0) begin errors++; $display("FAIL halt_done_pulse got %0b exp 0", a_done); end
        checks++; if (a_st !== 3'd2 || a_pc !== 64'h14 || a_ret !== 32'd2) begin errors++; $display("FAIL halt_hold got st=%0d pc=%0h ret=%0d exp 2 14 2", a_st, a_pc, a_ret); end
    endtask

    task automatic test_fault();
        do_reset_start();
        new_pc = 64'h20; cyc();
        in_inst = 1'b1; new_pc = 64'h77; cyc();
        checks++; if (a_st !== 3'd4 || a_pc !== 64'h20) begin errors++; $display("FAIL ins_state got st=%0d pc=%0h exp 4 20", a_st, a_pc); end
        checks++; if (a_ret !== 32'd1 || a_exec !== 32'd2 || a_run !== 1'b0) begin errors++; $display("FAIL ins_cnt got ret=%0d exec=%0d run=%0b exp 1 2 0", a_ret, a_exec, a_run); end
        in_inst = 1'b0; in_mem = 1'b1; cyc();
        checks++; if (a_st !== 3'd4) begin errors++; $display("FAIL stop_ignore_fault got %0d exp 4", a_st); end
        in_mem = 1'b0; start = 1'b1; cyc(); start = 1'b0;
        checks++; if (a_pc !== 64'd0 || a_st !== 3'd1 || a_exec !== 32'd0 || a_ret !== 32'd0 || a_run !== 1'b1) begin
            errors++; $display("FAIL restart got pc=%0h st=%0d exec=%0d ret=%0d run=%0b exp 0 1 0 0 1", a_pc, a_st, a_exec, a_ret, a_run); end
        in_mem = 1'b1; in_inst = 1'b1; new_pc = 64'h40; cyc();
        checks++; if (a_st !== 3'd3 || a_pc !== 64'd0 || a_ret !== 32'd0 || a_exec !== 32'd1) begin
            errors++; $display("FAIL adr got st=%0d pc=%0h ret=%0d exec=%0d exp 3 0 0 1", a_st, a_pc, a_ret, a_exec); end
        in_mem = 1'b0; in_inst = 1'b0;
    endtask

    task automatic test_single_step();
        do_reset_start();
        step_mode = 1'b1; step = 1'b0; hlt = 1'b1; new_pc = 64'h33;
        for (int i = 0; i < 5; i++) cyc();
        checks++; if (a_pc !== 64'd0 || a_exec !== 32'd0 || a_ret !== 32'd0 || a_run !== 1'b1) begin
            errors++; $display("FAIL step_frozen got pc=%0h exec=%0d ret=%0d run=%0b exp 0 0 0 1", a_pc, a_exec, a_ret, a_run); end
        hlt = 1'b0; step = 1'b1; new_pc = 64'd2; cyc();
        checks++; if (a_pc !== 64'd2) begin errors++; $display("FAIL step1_pc got %0d exp 2", a_pc); end
        step = 1'b0; new_pc = 64'd7; cyc();
        step = 1'b1; new_pc = 64'd12; cyc();
        step = 1'b0;
        checks++; if (a_pc !== 64'd12 || a_ret !== 32'd2 || a_exec !== 32'd2) begin
            errors++; $display("FAIL step2 got pc=%0d ret=%0d exec=%0d exp 12 2 2", a_pc, a_ret, a_exec); end
        step_mode = 1'b0; new_pc = 64'd13; cyc();
        checks++; if (a_pc !== 64'd13) begin errors++; $display("FAIL mode_switch got %0d exp 13", a_pc); end
    endtask

    task automatic test_watchdog();
        do_reset_start();
        for (int i = 1; i <= 3; i++) begin new_pc = 64'(4 * i); cyc(); end
        checks++; if (b_run !== 1'b1 || b_st !== 3'd1) begin errors++; $display("FAIL wdog_pre got run=%0b st=%0d exp 1 1", b_run, b_st); end
        new_pc = 64'd16; cyc();
        checks++; if (b_st !== 3'd5 || b_pc !== 64'd16) begin errors++; $display("FAIL wdog_tmo got st=%0d pc=%0d exp 5 16", b_st, b_pc); end
        checks++; if (b_exec !== 32'd4 || b_ret !== 32'd4 || b_done !== 1'b1 || b_run !== 1'b0) begin
            errors++; $display("FAIL wdog_cnt got exec=%0d ret=%0d done=%0b run=%0b exp 4 4 1 0", b_exec, b_ret, b_done, b_run); end
        checks++; if (a_run !== 1'b1 || a_st !== 3'd1) begin errors++; $display("FAIL wdog_off got run=%0b st=%0d exp 1 1", a_run, a_st); end
        new_pc = 64'd20; cyc();
        checks++; if (b_done !== 1'b0 || b_pc !== 64'd16) begin errors++; $display("FAIL wdog_hold got done=%0b pc=%0d exp 0 16", b_done, b_pc); end
        do_reset_start();
        for (int i = 1; i <= 3; i++) begin new_pc = 64'(4 * i); cyc(); end
        hlt = 1'b1; new_pc = 64'd16; cyc(); hlt = 1'b0;
        checks++; if (b_st !== 3'd2 || b_ret !== 32'd4 || b_exec !== 32'd4 || b_pc !== 64'd12) begin
            errors++; $display("FAIL wdog_hlt got st=%0d ret=%0d exec=%0d pc=%0d exp 2 4 4 12", b_st, b_ret, b_exec, b_pc); end
    endtask

    task automatic test_reset_mid_run();
        do_reset_start();
        for (int i = 1; i <= 7; i++) begin new_pc = 64'(4 * i); cyc(); end
        checks++; if (a_exec !== 32'd7 || a_pc !== 64'd28) begin errors++; $display("FAIL pre_rst got exec=%0d pc=%0d exp 7 28", a_exec, a_pc); end
        rst = 1'b1; cyc(); rst = 1'b0;
        checks++; if (a_run !== 1'b0 || a_pc !== 64'd0 || a_st !== 3'd1 || a_exec !== 32'd0 || a_ret !== 32'd0) begin
            errors++; $display("FAIL mid_rst got run=%0b pc=%0d st=%0d exec=%0d ret=%0d exp 0 0 1 0 0", a_run, a_pc, a_st, a_exec, a_ret); end
    endtask

    task automatic test_saturation();
        do_reset_start();
        for (int i = 1; i <= 10; i++) begin new_pc = 64'(i); cyc(); end
        checks++; if (c_exec !== 3'd7 || c_ret !== 3'd7 || c_run !== 1'b1 || c_pc !== 64'd10) begin
            errors++; $display("FAIL sat got exec=%0d ret=%0d run=%0b pc=%0d exp 7 7 1 10", c_exec, c_ret, c_run, c_pc); end
        checks++; if (a_exec !== 32'd10) begin errors++; $display("FAIL wide_cnt got %0d exp 10", a_exec); end
        hlt = 1'b1; cyc(); hlt = 1'b0;
        checks++; if (c_st !== 3'd2 || c_ret !== 3'd7 || c_exec !== 3'd7 || c_done !== 1'b1) begin
            errors++; $display("FAIL sat_hlt got st=%0d ret=%0d exec=%0d done=%0b exp 2 7 7 1", c_st, c_ret, c_exec, c_done); end
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_halt();
        test_fault();
        test_single_step();
        test_watchdog();
        test_reset_mid_run();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/y86_seq_ctrl.md
Name: y86_seq_ctrl

Overview:
- Architectural PC register and processor-status controller for the Y86-64 sequential core.
- Sits between pc_update/fetch and the top level, replacing the combinational PC/status glue with a clocked run-control FSM.
- Holds the PC and the sticky status code (AOK/HLT/ADR/INS, plus a watchdog timeout code).
- Counts executed and retired instructions and supports free-run or single-step mode.

Parameters:
- ADDR_W, 64, PC width in bits.
- RESET_PC, 0, PC value loaded on reset and on every start.
- CNT_W, 32, width of the executed/retired counters.
- WDOG_CYCLES, 0, executed-cycle limit before timeout; 0 disables the watchdog.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start_i  in  1  begin a run from RESET_PC; honoured in IDLE and STOP only.
- step_mode_i  in  1  1 = single-step, 0 = free-run.
- step_i  in  1  advance one instruction; used only when step_mode_i=1.
- hlt_i  in  1  fetch flagged a halt instruction.
- in_mem_i  in  1  fetch or memory flagged an invalid address.
- in_inst_i  in  1  fetch flagged an invalid instruction.
- new_pc_i  in  ADDR_W  next PC from pc_update.
- pc_o  out  ADDR_W  current PC, registered.
- status_o  out  3  1=AOK, 2=HLT, 3=ADR, 4=INS, 5=TMO.
- running_o  out  1  FSM is in RUN.
- done_o  out  1  one-cycle pulse on entry to STOP.
- exec_cnt_o  out  CNT_W  executed cycles in the current run.
- retired_o  out  CNT_W  retired instructions in the current run.

Behaviour:
- Reset
  - rst=1 at a clock edge: state=IDLE, pc_o=RESET_PC, status_o=1, running_o=0, done_o=0, both counters 0.
  - rst has priority over every other input and aborts a run mid-operation.
- States: IDLE, RUN, STOP.
  - IDLE: all outputs hold. start_i=1 moves to RUN next cycle, reloads pc_o=RESET_PC, sets status_o=1 and clears both counters.
  - STOP: same behaviour as IDLE. pc_o, status_o and the counters hold until start_i, so the fault state stays observable.
  - RUN: start_i is ignored.
- Executing cycle: a RUN cycle where step_mode_i=0, or where step_mode_i=1 and step_i=1. Non-executing RUN cycles change nothing.
- Each executing cycle evaluates the fault inputs with priority hlt_i > in_mem_i > in_inst_i:
  - hlt_i: status=2; pc_o holds; retired+1; exec+1; go to STOP.
  - in_mem_i: status=3; pc_o holds at the faulting instruction; retired unchanged; exec+1; go to STOP.
  - in_inst_i: status=4; same handling as in_mem_i.
  - No fault: pc_o<=new_pc_i; retired+1; exec+1; stay in RUN.
- Watchdog (WDOG_CYCLES>0):
  - Applies when an executing, fault-free cycle brings exec to WDOG_CYCLES.
  - That cycle's PC update and retire still happen. status then goes to 5 and the FSM goes to STOP.
  - A fault in the same cycle takes precedence over the timeout.
- Counters saturate at 2^CNT_W-1 and never wrap.
- done_o is high for exactly the first cycle after the RUN->STOP transition.
- running_o is high iff state=RUN (registered).
- Fault inputs are ignored outside RUN and in non-executing step cycles.
- Changing step_mode_i mid-run takes effect on the next cycle.

Test Plan:
- Reset then start: pulse rst, then start_i=1. pc_o=0, status_o=1, running_o=1. Drive new_pc_i=10, then 20, then 30 free-run. pc_o steps 10, 20, 30; retired_o=3; exec_cnt_o=3.
- Halt: in RUN at pc=0x14, assert hlt_i with in_mem_i=1 simultaneously. Next cycle: status_o=2, pc_o=0x14, retired increments, one-cycle done_o, running_o=0. Outputs hold with no start_i.
- ADR/INS: assert in_inst_i at pc=0x20. Expect status_o=4, pc_o=0x20, retired unchanged, STOP. Then start_i: pc_o=0, status_o=1, counters 0.
- Single-step: step_mode_i=1, step_i low for 5 cycles. PC and counters are frozen. Pulse step_i twice with new_pc_i=2, then 12. Expect pc_o=12, retired_o=2.
- Watchdog: WDOG_CYCLES=4, no faults. After 4 executing cycles: status_o=5, exec_cnt_o=4, retired_o=4, done_o pulse. A hlt_i on the 4th cycle instead gives status_o=2.
- Reset mid-run: assert rst during RUN with exec_cnt_o=7. Next cycle: IDLE, pc_o=RESET_PC, counters 0, status_o=1. Saturation with CNT_W=3: counters stick at 7.
